// File: rtl/io_port.sv
// io_port: memory-mapped 8-bit GPIO port with input synchronizer and rising-edge interrupts
module io_port #(
    parameter logic [7:0] RESET_DATA  = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Sel,
    input  logic        MemWrite,
    input  logic [3:0]  Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic [7:0]  PinIn,
    input  logic [7:0]  InOverride,
    output logic [7:0]  PortOut,
    output logic [31:0] TapData,
    output logic [31:0] TapControl,
    output logic        Irq
);
    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);

    logic [7:0]       latch, dir, ien, status, prev, sync_out, data_rd, set;
    logic [7:0]       sync_q [SYNC_STAGES];
    logic [ARM_W-1:0] arm;
    logic             wr_data, wr_ctrl, wr_stat, armed;
    logic             unused;

    assign unused   = ^{Addr[1:0], WriteData[31:16]};
    assign wr_data  = Sel & MemWrite & (Addr[3:2] == 2'd0);
    assign wr_ctrl  = Sel & MemWrite & (Addr[3:2] == 2'd1);
    assign wr_stat  = Sel & MemWrite & (Addr[3:2] == 2'd2);
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign armed    = (arm == ARM_W'(ARM_MAX));
    assign set      = armed ? (sync_out & ~prev & ~dir & ien) : 8'h00;
    assign data_rd  = (latch & dir) | (sync_out & ~dir);

    assign PortOut    = latch & dir;
    assign TapData    = {24'h0, data_rd};
    assign TapControl = {16'h0, ien, dir};
    assign Irq        = |status;
    assign ReadData   = !Sel                ? 32'h0 :
                        Addr[3:2] == 2'd0   ? {24'h0, data_rd} :
                        Addr[3:2] == 2'd1   ? {16'h0, ien, dir} :
                        Addr[3:2] == 2'd2   ? {24'h0, status} : 32'h0;

    // Input synchronizer chain, edge-history register and arming counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= 8'h00;
            prev <= 8'h00;
            arm  <= '0;
        end else begin
            sync_q[0] <= PinIn | InOverride;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            prev <= sync_out;
            if (!armed) arm <= arm + 1'b1;
        end
    end

    // Software-visible registers; an edge set beats a same-cycle W1C clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            latch  <= RESET_DATA;
            dir    <= 8'h00;
            ien    <= 8'h00;
            status <= 8'h00;
        end else begin
            if (wr_data) latch <= WriteData[7:0];
            if (wr_ctrl) begin
                dir <= WriteData[7:0];
                ien <= WriteData[15:8];
            end
            status <= (status & ~(wr_stat ? WriteData[7:0] : 8'h00)) | set;
        end
    end
endmodule

// File: tb/tb_io_port.sv
// tb_io_port: randomized and directed checks of io_port against a pin-history model
module tb_io_port;
    localparam int         S  = 2;
    localparam logic [7:0] RD = 8'h5A;

    logic        clk = 0, reset_n = 0, Sel = 0, MemWrite = 0;
    logic [3:0]  Addr = 0;
    logic [31:0] WriteData = 0, ReadData, TapData, TapControl;
    logic [7:0]  PinIn = 0, InOverride = 0, PortOut;
    logic        Irq;
    int          errors = 0, checks = 0;

    io_port #(.RESET_DATA(RD), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset_n(reset_n), .Sel(Sel), .MemWrite(MemWrite), .Addr(Addr),
        .WriteData(WriteData), .ReadData(ReadData), .PinIn(PinIn), .InOverride(InOverride),
        .PortOut(PortOut), .TapData(TapData), .TapControl(TapControl), .Irq(Irq)
    );

    always #5 clk = ~clk;

    // Model: h[n] is the raw pin value sampled n+1 edges ago; the synchronized value is
    // the raw value S edges old, and a rising edge compares it with the one before.
    logic [7:0] m_latch, m_dir, m_ien, m_st;
    logic [7:0] h [0:S];
    int         m_arm;
    bit         m_valid = 0;

    task automatic model_step();
        logic [7:0] set, w1c;
        logic       wen;
        if (!reset_n) begin
            m_latch = RD; m_dir = 0; m_ien = 0; m_st = 0; m_arm = 0; m_valid = 1;
            for (int i = 0; i <= S; i++) h[i] = 0;
        end else begin
            wen = Sel && MemWrite;
            set = (m_arm >= S + 1) ? (h[S-1] & ~h[S] & ~m_dir & m_ien) : 8'h00;
            w1c = (wen && Addr[3:2] == 2'd2) ? WriteData[7:0] : 8'h00;
            if (wen && Addr[3:2] == 2'd0) m_latch = WriteData[7:0];
            if (wen && Addr[3:2] == 2'd1) begin
                m_dir = WriteData[7:0];
                m_ien = WriteData[15:8];
            end
            m_st = (m_st & ~w1c) | set;
            for (int i = S; i > 0; i--) h[i] = h[i-1];
            h[0] = PinIn | InOverride;
            if (m_arm < S + 1) m_arm++;
        end
    endtask

    always @(posedge clk) model_step();

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [7:0]  d;
        logic [31:0] r;
        if (m_valid) begin
            d = (m_latch & m_dir) | (h[S-1] & ~m_dir);
            r = !Sel ? 32'h0 : Addr[3:2] == 2'd0 ? {24'h0, d} : Addr[3:2] == 2'd1 ? {16'h0, m_ien, m_dir} :
                Addr[3:2] == 2'd2 ? {24'h0, m_st} : 32'h0;
            chk("model_ReadData", ReadData, r);
            chk("model_PortOut", {24'h0, PortOut}, {24'h0, m_latch & m_dir});
            chk("model_TapData", TapData, {24'h0, d});
            chk("model_TapControl", TapControl, {16'h0, m_ien, m_dir});
            chk("model_Irq", {31'h0, Irq}, {31'h0, |m_st});
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        Sel = 1; MemWrite = 1; Addr = a; WriteData = d;
        step();
        Sel = 0; MemWrite = 0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string n);
        Sel = 1; MemWrite = 0; Addr = a;
        #1 chk(n, ReadData, exp);
        Sel = 0;
    endtask

    initial begin
        step(3);
        chk("rst_PortOut", {24'h0, PortOut}, 32'h0);
        chk("rst_Irq", {31'h0, Irq}, 32'h0);
        chk("rst_TapControl", TapControl, 32'h0);
        chk("rst_TapData", TapData, 32'h0);
        rd(4'h0, 32'h0, "rst_sel0_read");
        Sel = 0; Addr = 0; #1 chk("sel0_ReadData", ReadData, 32'h0);
        reset_n = 1;
        wr(4'h4, 32'h0000_00FF);
        rd(4'h0, 32'h5A, "reset_latch_read");
        chk("reset_latch_PortOut", {24'h0, PortOut}, 32'h5A);
        wr(4'h4, 32'hFFFF_00F0);
        wr(4'h0, 32'h0000_00A5);
        chk("s1_PortOut", {24'h0, PortOut}, 32'hA0);
        chk("s1_TapControl", TapControl, 32'h0000_00F0);
        rd(4'hC, 32'h0, "reserved_read");
        wr(4'h4, 32'h0);
        step(3);
        PinIn = 8'h3C;
        rd(4'h0, 32'h00, "s2_clk0");
        step();
        rd(4'h0, 32'h00, "s2_clk1");
        step();
        rd(4'h0, 32'h3C, "s2_clk2");
        chk("s2_TapData", TapData, 32'h3C);
        PinIn = 8'h00;
        step(3);
        wr(4'h4, 32'h0000_0100);
        PinIn = 8'h01;
        chk("s3_irq0", {31'h0, Irq}, 32'h0);
        step(2);
        chk("s3_irq2", {31'h0, Irq}, 32'h0);
        step();
        chk("s3_irq3", {31'h0, Irq}, 32'h1);
        rd(4'h8, 32'h01, "s3_status");
        wr(4'h8, 32'h0000_0001);
        chk("s3_irq_clr", {31'h0, Irq}, 32'h0);
        PinIn = 8'h00;
        step(3);
        PinIn = 8'h01;
        step(2);
        wr(4'h8, 32'h0000_0001);
        rd(4'h8, 32'h01, "s4_set_wins");
        wr(4'h8, 32'h0000_00FF);
        chk("s4_irq_clr", {31'h0, Irq}, 32'h0);
        PinIn = 8'hFF;
        reset_n = 0;
        step(2);
        reset_n = 1;
        wr(4'h4, 32'h0000_FF00);
        step(6);
        rd(4'h8, 32'h00, "s5_no_spurious");
        PinIn = 8'hFB;
        step(4);
        rd(4'h8, 32'h00, "s5_fall_no_set");
        PinIn = 8'hFF;
        step(3);
        rd(4'h8, 32'h04, "s5_bit2_rise");
        wr(4'h4, 32'h0);
        chk("s5_dir_chg_keeps_irq", {31'h0, Irq}, 32'h1);
        PinIn = 8'h00; InOverride = 8'h05;
        step(3);
        rd(4'h0, 32'h05, "s6_override");
        wr(4'h0, 32'h0000_00FF);
        wr(4'h4, 32'h0000_00FF);
        chk("s6_PortOut_pre", {24'h0, PortOut}, 32'hFF);
        reset_n = 0;
        step();
        chk("s6_PortOut_rst", {24'h0, PortOut}, 32'h0);
        chk("s6_Irq_rst", {31'h0, Irq}, 32'h0);
        reset_n = 1; InOverride = 0;
        for (int c = 0; c < 3000; c++) begin
            reset_n    = ($urandom_range(0, 299) != 0);
            Sel        = $urandom_range(0, 1) == 1;
            MemWrite   = $urandom_range(0, 3) == 0;
            Addr       = 4'($urandom);
            WriteData  = $urandom;
            if ($urandom_range(0, 3) == 0) PinIn = 8'($urandom);
            if ($urandom_range(0, 9) == 0) InOverride = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
